// File: rtl/mandel_scheduler_if.sv
// Job dispatch / result return bus between the frame scheduler and its two
// iteration cores.
//
//   job_valid  [1:0]   per-core job offer (one-hot or zero), scheduler -> core
//   job_ready  [1:0]   per-core job accept, core -> scheduler
//   job_x/job_y        pixel column/row of the offered job
//   job_addr           framebuffer address of the offered job
//   res_valid  [1:0]   per-core result available, held until acknowledged
//   res_addr0/1        address echoed back by core 0 / core 1
//   res_iter0/1        iteration count from core 0 / core 1
//   res_ack    [1:0]   one-hot result grant, scheduler -> core
//
// master: scheduler side. slave: iteration-core side.
interface mandel_scheduler_if #(
    parameter int ADDR_W = 19,
    parameter int WIDTH  = 7
);
    logic [1:0]        job_valid;
    logic [1:0]        job_ready;
    logic [9:0]        job_x;
    logic [9:0]        job_y;
    logic [ADDR_W-1:0] job_addr;
    logic [1:0]        res_valid;
    logic [ADDR_W-1:0] res_addr0;
    logic [ADDR_W-1:0] res_addr1;
    logic [WIDTH-1:0]  res_iter0;
    logic [WIDTH-1:0]  res_iter1;
    logic [1:0]        res_ack;

    modport master (
        output job_valid, job_x, job_y, job_addr, res_ack,
        input  job_ready, res_valid, res_addr0, res_addr1, res_iter0, res_iter1
    );

    modport slave (
        input  job_valid, job_x, job_y, job_addr, res_ack,
        output job_ready, res_valid, res_addr0, res_addr1, res_iter0, res_iter1
    );
endinterface

// File: rtl/mandel_scheduler.sv
// Mandelbrot frame scheduler.
// Walks every pixel of one frame in raster order, hands each pixel to one of
// two iteration cores, and funnels the cores' results into a single
// registered framebuffer write port.
//
// Ports:
//   CLK_100MHz  system clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle pulse, starts a frame when idle
//   busy        high while a frame is in progress
//   done        one-cycle pulse after the last pixel has been written
//   jobs        job/result bus to the two cores (master side)
//   wea/addr_w/dina  registered BRAM write port
module mandel_scheduler #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int WIDTH  = 7,
    parameter int ADDR_W = 19
) (
    input  logic              CLK_100MHz,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    mandel_scheduler_if.master jobs,
    output logic              wea,
    output logic [ADDR_W-1:0] addr_w,
    output logic [WIDTH-1:0]  dina
);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic [1:0]        job_valid_r;
    logic [1:0]        core_busy_r;
    logic [1:0]        offer_s;
    logic [1:0]        ack_s;
    logic              transfer_s;
    logic              last_pix_s;
    logic              both_res_s;
    logic              disp_ptr_r;
    logic              res_ptr_r;
    logic [9:0]        x_r;
    logic [9:0]        y_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wea_r;
    logic [ADDR_W-1:0] addr_w_r;
    logic [WIDTH-1:0]  dina_r;
    logic              busy_r;
    logic              done_r;

    // job_valid_r is one-hot, so any overlap with ready is the single transfer
    assign transfer_s = |(job_valid_r & jobs.job_ready);
    assign last_pix_s = (x_r == X_LAST) && (y_r == Y_LAST);
    assign both_res_s = (jobs.res_valid == 2'b11);

    // State register
    always_ff @(posedge CLK_100MHz or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_DISPATCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (transfer_s && last_pix_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_DISPATCH;
                end
            end
            ST_DRAIN: begin
                // every core returned its result and the final write has left
                if ((core_busy_r == 2'b00) && !wea_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Choose the core that receives the next offer. Only cores already idle in
    // the registered busy map qualify, so a core freed by an ack this cycle is
    // offered work one cycle later at the earliest.
    always_comb begin
        offer_s = 2'b00;
        if ((state_r == ST_DISPATCH) && (job_valid_r == 2'b00)) begin
            case (~core_busy_r)
                2'b11:   offer_s = disp_ptr_r ? 2'b10 : 2'b01;
                2'b01:   offer_s = 2'b01;
                2'b10:   offer_s = 2'b10;
                default: offer_s = 2'b00;
            endcase
        end else begin
            offer_s = 2'b00;
        end
    end

    // Result grant: a lone request wins outright, a tie goes to the pointer
    always_comb begin
        ack_s = 2'b00;
        case (jobs.res_valid)
            2'b11:   ack_s = res_ptr_r ? 2'b10 : 2'b01;
            2'b01:   ack_s = 2'b01;
            2'b10:   ack_s = 2'b10;
            default: ack_s = 2'b00;
        endcase
    end

    // Job offer register and raster counters
    always_ff @(posedge CLK_100MHz or negedge reset) begin
        if (!reset) begin
            job_valid_r <= 2'b00;
            disp_ptr_r  <= 1'b0;
            x_r         <= 10'd0;
            y_r         <= 10'd0;
            addr_r      <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            job_valid_r <= 2'b00;
            x_r         <= 10'd0;
            y_r         <= 10'd0;
            addr_r      <= '0;
        end else if (transfer_s) begin
            job_valid_r <= 2'b00;
            disp_ptr_r  <= ~disp_ptr_r;
            // the last pixel leaves the counters in place so addr never exceeds
            // the final framebuffer location
            if (!last_pix_s) begin
                addr_r <= addr_r + ADDR_W'(1);
                if (x_r == X_LAST) begin
                    x_r <= 10'd0;
                    y_r <= y_r + 10'd1;
                end else begin
                    x_r <= x_r + 10'd1;
                end
            end
        end else if (offer_s != 2'b00) begin
            job_valid_r <= offer_s;
        end
    end

    // Per-core occupancy: set on job transfer, cleared on result grant
    always_ff @(posedge CLK_100MHz or negedge reset) begin
        if (!reset) begin
            core_busy_r <= 2'b00;
        end else begin
            core_busy_r <= (core_busy_r & ~ack_s) | (transfer_s ? job_valid_r : 2'b00);
        end
    end

    // Result round-robin pointer, advanced only when both cores contend
    always_ff @(posedge CLK_100MHz or negedge reset) begin
        if (!reset) begin
            res_ptr_r <= 1'b0;
        end else if (both_res_s) begin
            res_ptr_r <= ~res_ptr_r;
        end
    end

    // Registered framebuffer write of the granted result
    always_ff @(posedge CLK_100MHz or negedge reset) begin
        if (!reset) begin
            wea_r    <= 1'b0;
            addr_w_r <= '0;
            dina_r   <= '0;
        end else begin
            wea_r <= |ack_s;
            if (ack_s[1]) begin
                addr_w_r <= jobs.res_addr1;
                dina_r   <= jobs.res_iter1;
            end else if (ack_s[0]) begin
                addr_w_r <= jobs.res_addr0;
                dina_r   <= jobs.res_iter0;
            end
        end
    end

    // Status flags decoded from the upcoming state
    always_ff @(posedge CLK_100MHz or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_DISPATCH) || (state_next_s == ST_DRAIN);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign jobs.job_valid = job_valid_r;
    assign jobs.job_x     = x_r;
    assign jobs.job_y     = y_r;
    assign jobs.job_addr  = addr_r;
    assign jobs.res_ack   = ack_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign wea    = wea_r;
    assign addr_w = addr_w_r;
    assign dina   = dina_r;

endmodule

// File: tb/tb_mandel_scheduler.sv
// Testbench for mandel_scheduler on a 4x3 frame with two modelled iteration
// cores of random latency (1-20 cycles) returning addr[6:0] ^ 7'h55.
module tb_mandel_scheduler;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int W  = 7;
    localparam int AW = 19;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, wea;
    logic [AW-1:0] addr_w;
    logic [W-1:0]  dina;

    mandel_scheduler_if #(.ADDR_W(AW), .WIDTH(W)) bus ();

    mandel_scheduler #(.H_RES(H), .V_RES(V), .WIDTH(W), .ADDR_W(AW)) dut (
        .CLK_100MHz(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
        .jobs(bus), .wea(wea), .addr_w(addr_w), .dina(dina)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // core model
    logic [1:0]    c_busy, c_resv;
    int            c_cnt [2];
    logic [AW-1:0] c_addr [2];
    logic          block = 1'b0;
    logic          manual = 1'b0;
    logic [1:0]    man_valid = 2'b00;
    logic [AW-1:0] man_addr0 = '0, man_addr1 = '0;
    logic [W-1:0]  man_iter0 = '0, man_iter1 = '0;

    assign bus.job_ready = ~(c_busy | c_resv) & {2{~block}};
    assign bus.res_valid = manual ? man_valid : c_resv;
    assign bus.res_addr0 = manual ? man_addr0 : c_addr[0];
    assign bus.res_addr1 = manual ? man_addr1 : c_addr[1];
    assign bus.res_iter0 = manual ? man_iter0 : (c_addr[0][W-1:0] ^ 7'h55);
    assign bus.res_iter1 = manual ? man_iter1 : (c_addr[1][W-1:0] ^ 7'h55);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_busy <= 2'b00;
            c_resv <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                c_cnt[i]  <= 0;
                c_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (c_resv[i] && bus.res_ack[i] && !manual) c_resv[i] <= 1'b0;
                if (c_busy[i]) begin
                    if (c_cnt[i] <= 1) begin
                        c_busy[i] <= 1'b0;
                        c_resv[i] <= 1'b1;
                    end else begin
                        c_cnt[i] <= c_cnt[i] - 1;
                    end
                end else if (!c_resv[i] && bus.job_valid[i] && bus.job_ready[i]) begin
                    c_busy[i] <= 1'b1;
                    c_addr[i] <= bus.job_addr;
                    c_cnt[i]  <= int'($urandom_range(20, 1));
                end
            end
        end
    end

    // monitor
    int       wr_count, wr_bad, done_count, acc, busy_viol;
    int       hits [16];
    logic [W-1:0] dat [16];
    int       jq_x [16], jq_y [16], jq_a [16];

    always @(negedge clk) begin
        if (rst_n) begin
            if (wea) begin
                wr_count++;
                if (addr_w < AW'(NPIX)) begin
                    hits[addr_w[3:0]]++;
                    dat[addr_w[3:0]] = dina;
                end else begin
                    wr_bad++;
                end
            end
            if (done) done_count++;
            if (bus.job_valid == 2'b11 || (|(bus.job_valid & (c_busy | c_resv)))) busy_viol++;
            if (|(bus.job_valid & bus.job_ready)) begin
                if (acc < 16) begin
                    jq_x[acc] = int'(bus.job_x);
                    jq_y[acc] = int'(bus.job_y);
                    jq_a[acc] = int'(bus.job_addr);
                end
                acc++;
            end
        end
    end

    task automatic clear_mon();
        wr_count = 0; wr_bad = 0; done_count = 0; acc = 0; busy_viol = 0;
        for (int i = 0; i < 16; i++) begin
            hits[i] = 0; dat[i] = '0; jq_x[i] = -1; jq_y[i] = -1; jq_a[i] = -1;
        end
    endtask

    task automatic run_frame(output int berr, output bit tmo);
        berr = 0; tmo = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done === 1'b1) begin tmo = 1'b0; break; end
            if (busy !== 1'b1) berr++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({busy, done, wea} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {busy, done, wea}); end
        checks++; if (bus.job_valid !== 2'b00 || bus.res_ack !== 2'b00) begin failures++; $display("FAIL reset_handshake: got valid=%b ack=%b expected 00/00", bus.job_valid, bus.res_ack); end
        checks++; if (addr_w !== '0 || dina !== '0) begin failures++; $display("FAIL reset_write: got addr=%0d dina=%0d expected 0/0", addr_w, dina); end
        checks++; if (bus.job_x !== 10'd0 || bus.job_y !== 10'd0 || bus.job_addr !== '0) begin failures++; $display("FAIL reset_job: got x=%0d y=%0d a=%0d expected 0", bus.job_x, bus.job_y, bus.job_addr); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        int berr; bit tmo;
        clear_mon();
        run_frame(berr, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL frame_timeout: done not seen within 3000 cycles"); end
        checks++; if (berr != 0) begin failures++; $display("FAIL frame_busy: got %0d cycles with busy low, expected 0", berr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_busy_at_done: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || done_count != 1) begin failures++; $display("FAIL frame_done_pulse: got done=%b count=%0d expected 0/1", done, done_count); end
        checks++; if (wr_count != NPIX || wr_bad != 0) begin failures++; $display("FAIL frame_writes: got %0d (bad %0d) expected %0d", wr_count, wr_bad, NPIX); end
        for (int a = 0; a < NPIX; a++) begin
            logic [W-1:0] exp_d;
            exp_d = W'(a) ^ 7'h55;
            checks++; if (hits[a] != 1 || dat[a] !== exp_d) begin failures++; $display("FAIL frame_pixel[%0d]: got hits=%0d dina=%h expected 1/%h", a, hits[a], dat[a], exp_d); end
        end
        checks++; if (acc != NPIX) begin failures++; $display("FAIL job_count: got %0d expected %0d", acc, NPIX); end
        for (int k = 0; k < NPIX; k++) begin
            checks++; if (jq_x[k] != k % H || jq_y[k] != k / H || jq_a[k] != k) begin
                failures++; $display("FAIL job_fields[%0d]: got x=%0d y=%0d a=%0d expected %0d/%0d/%0d", k, jq_x[k], jq_y[k], jq_a[k], k % H, k / H, k);
            end
        end
        checks++; if (busy_viol != 0) begin failures++; $display("FAIL job_to_busy_core: got %0d offers expected 0", busy_viol); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_ack [4];
        exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01; exp_ack[3] = 2'b10;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        manual = 1'b1; man_valid = 2'b11;
        man_addr0 = AW'(100); man_iter0 = 7'h11;
        man_addr1 = AW'(200); man_iter1 = 7'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.res_ack !== exp_ack[k]) begin failures++; $display("FAIL sim_ack[%0d]: got %b expected %b", k, bus.res_ack, exp_ack[k]); end
            @(posedge clk); #1;
            checks++; if (wea !== 1'b1 || addr_w !== (k % 2 == 0 ? AW'(100) : AW'(200)) || dina !== (k % 2 == 0 ? 7'h11 : 7'h22)) begin
                failures++; $display("FAIL sim_write[%0d]: got wea=%b addr=%0d dina=%h", k, wea, addr_w, dina);
            end
        end
        man_valid = 2'b10; #1;
        checks++; if (bus.res_ack !== 2'b10) begin failures++; $display("FAIL single_ack: got %b expected 10", bus.res_ack); end
        @(posedge clk); #1;
        man_valid = 2'b11; #1;
        checks++; if (bus.res_ack !== 2'b01) begin failures++; $display("FAIL ptr_hold: got %b expected 01", bus.res_ack); end
        @(posedge clk); #1;
        man_valid = 2'b00; #1;
        checks++; if (bus.res_ack !== 2'b00 || wea !== 1'b1 || addr_w !== AW'(100)) begin failures++; $display("FAIL idle_ack: got ack=%b wea=%b addr=%0d expected 00/1/100", bus.res_ack, wea, addr_w); end
        @(posedge clk); #1;
        checks++; if (wea !== 1'b0) begin failures++; $display("FAIL no_grant_wea: got %b expected 0", wea); end
        manual = 1'b0;
    endtask

    task automatic test_backpressure();
        int n, bad; logic [1:0] v0; bit ok;
        clear_mon();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (acc >= 3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL bp_progress: got %0d jobs expected 3", acc); end
        @(posedge clk); #1; block = 1'b1; n = acc;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.job_valid != 2'b00) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL bp_offer: got no job_valid expected an offer"); end
        v0 = bus.job_valid;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (bus.job_valid !== v0 || bus.job_x !== 10'(n % H) || bus.job_y !== 10'(n / H) || bus.job_addr !== AW'(n) || acc != n) begin
                failures++; $display("FAIL bp_stable[%0d]: got v=%b x=%0d y=%0d a=%0d jobs=%0d expected %b/%0d/%0d/%0d/%0d", k, bus.job_valid, bus.job_x, bus.job_y, bus.job_addr, acc, v0, n % H, n / H, n, n);
            end
        end
        @(posedge clk); #1; block = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        bad = 0;
        for (int a = 0; a < NPIX; a++) if (hits[a] != 1 || dat[a] !== (W'(a) ^ 7'h55)) bad++;
        checks++; if (!ok || wr_count != NPIX || bad != 0 || done_count != 1) begin
            failures++; $display("FAIL bp_frame: got done=%0d writes=%0d badpix=%0d pulses=%0d expected 1/%0d/0/1", ok, wr_count, bad, done_count, NPIX);
        end
    endtask

    task automatic test_reset_mid_frame();
        int berr, bad; bit tmo, ok;
        clear_mon();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (wr_count >= 5) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL mid_progress: got %0d writes expected 5", wr_count); end
        @(posedge clk); #3; rst_n = 1'b0; #1;
        checks++; if ({busy, done, wea} !== 3'b000) begin failures++; $display("FAIL mid_flags: got %b expected 000", {busy, done, wea}); end
        checks++; if (bus.job_valid !== 2'b00 || bus.res_ack !== 2'b00) begin failures++; $display("FAIL mid_handshake: got %b/%b expected 00/00", bus.job_valid, bus.res_ack); end
        checks++; if (addr_w !== '0 || dina !== '0 || bus.job_x !== 10'd0 || bus.job_y !== 10'd0 || bus.job_addr !== '0) begin
            failures++; $display("FAIL mid_data: got addr=%0d dina=%0d x=%0d y=%0d a=%0d expected 0", addr_w, dina, bus.job_x, bus.job_y, bus.job_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        clear_mon();
        run_frame(berr, tmo);
        @(negedge clk);
        bad = 0;
        for (int a = 0; a < NPIX; a++) if (hits[a] != 1 || dat[a] !== (W'(a) ^ 7'h55)) bad++;
        checks++; if (tmo || berr != 0 || wr_count != NPIX || bad != 0 || done_count != 1) begin
            failures++; $display("FAIL mid_refresh: got tmo=%0d busyerr=%0d writes=%0d badpix=%0d pulses=%0d expected 0/0/%0d/0/1", tmo, berr, wr_count, bad, done_count, NPIX);
        end
    endtask

    task automatic test_start_while_busy();
        int bad; bit ok;
        clear_mon();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            start = (c % 6 == 3) && (c < 60);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        bad = 0;
        for (int a = 0; a < NPIX; a++) if (hits[a] != 1) bad++;
        checks++; if (!ok || wr_count != NPIX || bad != 0) begin failures++; $display("FAIL sb_writes: got done=%0d writes=%0d badpix=%0d expected 1/%0d/0", ok, wr_count, bad, NPIX); end
        checks++; if (done_count != 1 || busy !== 1'b0) begin failures++; $display("FAIL sb_done: got pulses=%0d busy=%b expected 1/0", done_count, busy); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single_frame();
        test_simultaneous();
        test_backpressure();
        test_reset_mid_frame();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
